// File: rtl/sop_sweep_ctrl.sv
// Exhaustive sweep sequencer for an N_IN-input combinational SoP evaluator.
// Optional mismatch counter output err_cnt is enabled by defining SOP_SWEEP_ERRCNT_EN.
module sop_sweep_ctrl #(
  parameter int N_IN       = 4,
  parameter int SETTLE_CYC = 1,
  localparam int TT_W      = 2 ** N_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [TT_W-1:0]   exp_tt,
  output logic [N_IN-1:0]   ev_in,
  input  logic              ev_out,
  output logic              busy,
  output logic              done,
  output logic [TT_W-1:0]   tt,
  output logic              match,
  output logic              fail_vld,
  output logic [N_IN-1:0]   first_fail,
`ifdef SOP_SWEEP_ERRCNT_EN
  output logic [N_IN:0]     err_cnt,
`endif
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = 4;
  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   ev_in_q, ev_in_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TT_W-1:0]   exp_q, exp_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic              match_q, match_d;
  logic              fail_vld_q, fail_vld_d;
  logic [N_IN-1:0]   first_fail_q, first_fail_d;
`ifdef SOP_SWEEP_ERRCNT_EN
  logic [N_IN:0]     err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ev_in_q      <= '0;
      cnt_q        <= '0;
      exp_q        <= '0;
      tt_q         <= '0;
      match_q      <= 1'b0;
      fail_vld_q   <= 1'b0;
      first_fail_q <= '0;
`ifdef SOP_SWEEP_ERRCNT_EN
      err_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ev_in_q      <= ev_in_d;
      cnt_q        <= cnt_d;
      exp_q        <= exp_d;
      tt_q         <= tt_d;
      match_q      <= match_d;
      fail_vld_q   <= fail_vld_d;
      first_fail_q <= first_fail_d;
`ifdef SOP_SWEEP_ERRCNT_EN
      err_q        <= err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    ev_in_d      = ev_in_q;
    cnt_d        = cnt_q;
    exp_d        = exp_q;
    tt_d         = tt_q;
    match_d      = match_q;
    fail_vld_d   = fail_vld_q;
    first_fail_d = first_fail_q;
`ifdef SOP_SWEEP_ERRCNT_EN
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d        = exp_tt;
          tt_d         = '0;
          match_d      = 1'b0;
          fail_vld_d   = 1'b0;
          first_fail_d = '0;
`ifdef SOP_SWEEP_ERRCNT_EN
          err_d        = '0;
`endif
          ev_in_d      = '0;
          cnt_d        = CNT_W'(SETTLE_CYC);
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          match_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          match_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          tt_d[ev_in_q] = ev_out;
          if (ev_out != exp_q[ev_in_q]) begin
`ifdef SOP_SWEEP_ERRCNT_EN
            if (err_q != (N_IN+1)'(TT_W)) err_d = err_q + (N_IN+1)'(1);
`endif
            if (!fail_vld_q) begin
              fail_vld_d   = 1'b1;
              first_fail_d = ev_in_q;
            end
          end
          if (ev_in_q == LAST_IDX) begin
            // Compare the fully assembled table now so match is valid alongside done.
            match_d = (tt_d == exp_q);
            state_d = S_DONE;
          end else begin
            ev_in_d = ev_in_q + N_IN'(1);
            cnt_d   = CNT_W'(SETTLE_CYC);
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ev_in      = ev_in_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign tt         = tt_q;
  assign match      = match_q;
  assign fail_vld   = fail_vld_q;
  assign first_fail = first_fail_q;
  assign dbg_state  = state_q;
`ifdef SOP_SWEEP_ERRCNT_EN
  assign err_cnt    = err_q;
`endif

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Directed bench for sop_sweep_ctrl: vector table of full sweeps plus hand-written
// sequences for settle timing, abort, start re-pulse and mid-sweep reset.
module tb_sop_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start, abort, mode;
  logic [15:0] exp_tt;
  logic [3:0]  ev_in;
  logic        ev_out;
  logic        busy, done, match, fail_vld;
  logic [15:0] tt;
  logic [3:0]  first_fail;
  logic [1:0]  dbg_state;
  logic [4:0]  err_cnt;

  logic        start2;
  logic [15:0] exp2;
  logic [3:0]  ev_in2;
  logic        ev_out2;
  logic        busy2, done2, match2, fail2;
  logic [15:0] tt2;
  logic [3:0]  ff2;
  logic [1:0]  st2;
  logic [4:0]  err2;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic f_eval(input logic [3:0] v);
    return (v[3] & v[2]) | (v[2] & ~v[1] & v[0]) | (~v[3] & ~v[2] & v[1] & v[0]);
  endfunction

  assign ev_out  = mode ? 1'b1 : f_eval(ev_in);
  assign ev_out2 = f_eval(ev_in2);

  sop_sweep_ctrl #(.N_IN(4), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_tt(exp_tt),
    .ev_in(ev_in), .ev_out(ev_out), .busy(busy), .done(done), .tt(tt),
    .match(match), .fail_vld(fail_vld), .first_fail(first_fail),
`ifdef SOP_SWEEP_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .dbg_state(dbg_state)
  );

  sop_sweep_ctrl #(.N_IN(4), .SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .exp_tt(exp2),
    .ev_in(ev_in2), .ev_out(ev_out2), .busy(busy2), .done(done2), .tt(tt2),
    .match(match2), .fail_vld(fail2), .first_fail(ff2),
`ifdef SOP_SWEEP_ERRCNT_EN
    .err_cnt(err2),
`endif
    .dbg_state(st2)
  );

`ifndef SOP_SWEEP_ERRCNT_EN
  assign err_cnt = '0;
  assign err2    = '0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Cycle c is the cycle after the c-th rising edge following acceptance (edge 0).
  task automatic run_sweep(input logic [15:0] e, input logic m, input int limit,
                           input int rp_a, input int rp_b,
                           output int done_cyc, output int done_cnt,
                           output int busy_cnt, output logic match_at_done);
    done_cyc = 0; done_cnt = 0; busy_cnt = 0; match_at_done = 1'b0;
    @(negedge clk);
    exp_tt = e; mode = m; start = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      start = (c == rp_a) || (c == rp_b);
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = c;
          match_at_done = match;
        end
      end
      if (busy) busy_cnt++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [15:0] exp_in;
    logic        m;
    logic [15:0] tt_e;
    logic        match_e;
    logic        fail_e;
    logic [3:0]  ff_e;
    logic [4:0]  err_e;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int dc, dn, bc, waited, ev_bad, dcyc2;
    logic mad;

    vecs[0] = '{16'hF028, 1'b0, 16'hF028, 1'b1, 1'b0, 4'd0, 5'd0};
    vecs[1] = '{16'hF02C, 1'b0, 16'hF028, 1'b0, 1'b1, 4'd2, 5'd1};
    vecs[2] = '{16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 4'd0, 5'd16};
    vecs[3] = '{16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 4'd0, 5'd0};
    vecs[4] = '{16'h0FD7, 1'b0, 16'hF028, 1'b0, 1'b1, 4'd0, 5'd16};
    vecs[5] = '{16'h0000, 1'b0, 16'hF028, 1'b0, 1'b1, 4'd3, 5'd6};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; exp_tt = '0;
    start2 = 1'b0; exp2 = '0;
    #1;
    check("rst_outputs", {busy, done, match, fail_vld, tt, ev_in, first_fail, dbg_state}, '0);
    check("rst_err_cnt", {27'd0, err_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", {busy, done, dbg_state}, '0);

    // table-driven full sweeps
    for (int i = 0; i < 6; i++) begin
      run_sweep(vecs[i].exp_in, vecs[i].m, 40, -1, -1, dc, dn, bc, mad);
      check($sformatf("v%0d_done_cyc", i), dc, 33);
      check($sformatf("v%0d_done_cnt", i), dn, 1);
      check($sformatf("v%0d_busy_cnt", i), bc, 33);
      check($sformatf("v%0d_match_at_done", i), {31'd0, mad}, {31'd0, vecs[i].match_e});
      check($sformatf("v%0d_tt", i), {16'd0, tt}, {16'd0, vecs[i].tt_e});
      check($sformatf("v%0d_match_held", i), {31'd0, match}, {31'd0, vecs[i].match_e});
      check($sformatf("v%0d_fail_vld", i), {31'd0, fail_vld}, {31'd0, vecs[i].fail_e});
      check($sformatf("v%0d_first_fail", i), {28'd0, first_fail}, {28'd0, vecs[i].ff_e});
      check($sformatf("v%0d_ev_in_hold", i), {28'd0, ev_in}, 32'd15);
`ifdef SOP_SWEEP_ERRCNT_EN
      check($sformatf("v%0d_err_cnt", i), {27'd0, err_cnt}, {27'd0, vecs[i].err_e});
`endif
    end

    // SETTLE_CYC = 3: each ev_in value held 4 cycles, done in cycle 65
    @(negedge clk);
    exp2 = 16'hF028; start2 = 1'b1;
    ev_bad = 0; dcyc2 = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (c <= 64 && ev_in2 !== 4'((c - 1) / 4)) ev_bad++;
      if (done2 && dcyc2 == 0) dcyc2 = c;
    end
    check("s3_ev_in_sequence", ev_bad, 0);
    check("s3_done_cyc", dcyc2, 65);
    check("s3_tt", {16'd0, tt2}, 32'h0000F028);
    check("s3_match", {31'd0, match2}, 32'd1);

    // abort while ev_in = 6
    @(negedge clk);
    exp_tt = 16'hF028; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (ev_in != 4'd6 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("abort_reach_6", {31'd0, waited < 40}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_tt", {16'd0, tt}, 32'h00000028);
    check("abort_match", {31'd0, match}, 32'd0);
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("abort_no_done", dn, 0);
    run_sweep(16'hF028, 1'b0, 40, -1, -1, dc, dn, bc, mad);
    check("post_abort_done_cyc", dc, 33);
    check("post_abort_tt", {16'd0, tt}, 32'h0000F028);
    check("post_abort_match", {31'd0, mad}, 32'd1);

    // start re-pulsed at cycles 5 and 33 is ignored
    run_sweep(16'hF028, 1'b0, 80, 5, 33, dc, dn, bc, mad);
    check("repulse_done_cnt", dn, 1);
    check("repulse_done_cyc", dc, 33);
    check("repulse_busy_cnt", bc, 33);

    // asynchronous reset in cycle 10 of a sweep
    @(negedge clk);
    exp_tt = 16'hF02C; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {busy, done, match, fail_vld, tt, ev_in, first_fail, dbg_state}, '0);
    check("midrst_err_cnt", {27'd0, err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || done) dn++;
    end
    check("post_rst_idle", dn, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sop_sweep_ctrl.md
Name: sop_sweep_ctrl

Overview:
- Sequencer that exhaustively exercises a combinational N_IN-input sum-of-products evaluator, such as the 4-input SoP gate network.
- Drives every input combination in ascending order, waits a settle time, samples the evaluator output and assembles a truth-table vector.
- Compares that vector against an expected table and reports match and first failing minterm.
- Sits between a test/config host (start/done handshake) and the evaluator instance (drive/sample ports).

Parameters:
- N_IN, 4, evaluator input count; truth table width TT_W = 2**N_IN. Legal range 2..6.
- SETTLE_CYC, 1, cycles the driven vector is held before sampling. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request sweep; accepted only in IDLE
- abort  input  1  synchronous cancel of a running sweep
- exp_tt  input  TT_W  expected table; bit k = f(k); captured at start acceptance
- ev_in  output  N_IN  vector driven to evaluator; MSB = evaluator i1, LSB = last input
- ev_out  input  1  evaluator output
- busy  output  1  high from cycle after acceptance until DONE is left
- done  output  1  one-cycle pulse, sweep complete
- tt  output  TT_W  captured truth table; bit k = sampled ev_out for ev_in = k
- match  output  1  tt == captured exp_tt; valid while done is high, held until next acceptance
- fail_vld  output  1  at least one mismatch in last sweep
- first_fail  output  N_IN  lowest mismatching index; 0 when fail_vld = 0

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - ev_in, tt, first_fail, and the settle counter are 0.
  - busy, done, match, fail_vld are 0.
  - Reset mid-sweep discards all progress.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: if start = 1 at a clock edge, then on that edge:
  - capture exp_tt;
  - clear tt, fail_vld, first_fail and match;
  - set ev_in = 0 and settle counter = SETTLE_CYC;
  - go to SETTLE.
- SETTLE: counter decrements each cycle. When counter = 1, go to SAMPLE. ev_in is held for exactly SETTLE_CYC cycles.
- SAMPLE (1 cycle):
  - tt[ev_in] <= ev_out.
  - If ev_out != exp_q[ev_in] and fail_vld = 0: set fail_vld and first_fail = ev_in.
  - If ev_in = TT_W-1: go to DONE.
  - Otherwise: ev_in increments, counter reloads, go to SETTLE.
- DONE (1 cycle):
  - done = 1, match = (tt == exp_q).
  - Go to IDLE; busy drops on the same edge.
- Latency: done is high in cycle TT_W*(SETTLE_CYC+1)+1 after the acceptance edge. Defaults give cycle 33.
- ev_in does not wrap past TT_W-1. After DONE it holds TT_W-1 until the next acceptance.
- start while busy is ignored, with no queuing. start in the DONE cycle is also ignored.
- abort = 1 in SETTLE or SAMPLE:
  - next state is IDLE; no done pulse;
  - tt keeps its partial contents; match = 0; fail_vld/first_fail keep their current values.
- abort in IDLE or DONE has no effect.
- abort and start together in IDLE: start wins.
- tt, match, fail_vld and first_fail are stable outside SAMPLE/DONE updates.

Optional Feature:
- Macro SOP_SWEEP_ERRCNT_EN.
- When defined:
  - Extra output err_cnt, N_IN+1 bits, counts mismatching samples in the current sweep.
  - Cleared at acceptance; +1 per mismatching SAMPLE; saturates at TT_W; 0 on reset.
- When not defined: port and counter are absent; all other behaviour identical.

Test Plan:
- Evaluator modelled as f = i1&i2 | i2&~i3&i4 | ~i1&~i2&i3&i4. Defaults; exp_tt = 16'hF028; pulse start -> done in cycle 33; tt = 16'hF028; match = 1; fail_vld = 0; busy high cycles 1..33.
- Same evaluator, exp_tt = 16'hF02C -> tt = 16'hF028, match = 0, fail_vld = 1, first_fail = 2; err_cnt = 1 when the macro is defined.
- SETTLE_CYC = 3; check ev_in each cycle -> each value held 4 cycles (3 settle + 1 sample), values 0..15 in order; done in cycle 65.
- abort asserted in the cycle ev_in = 6 -> IDLE next cycle, done never pulses, busy = 0, tt[5:0] = 6'h28, upper bits 0; new start then completes normally.
- start re-pulsed at cycles 5 and 33 of a running sweep -> ignored, a single done pulse; rst_n low at cycle 10 -> all outputs 0 immediately, state IDLE.
- Constant-1 evaluator with exp_tt = 16'h0000 -> tt = 16'hFFFF, first_fail = 0, err_cnt = 16 (saturation bound) when the macro is defined.
